// File: rtl/palette_lut_if.sv
// Pixel-stream and CPU palette signals of palette_lut, with master/slave views.
// PALETTE_READBACK_EN adds cpu_re / cpu_rdata / cpu_rvalid.
interface palette_lut_if #(
  parameter int CHANNEL_BITS = 3,
  parameter int INDEX_BITS   = 8
);
  localparam int EW = 3*CHANNEL_BITS;

  logic                    pix_valid_in;
  logic [INDEX_BITS-1:0]   pix_index;
  logic                    pix_blank;
  logic                    pix_valid_out;
  logic [CHANNEL_BITS-1:0] r;
  logic [CHANNEL_BITS-1:0] g;
  logic [CHANNEL_BITS-1:0] b;
  logic                    cpu_we;
  logic [INDEX_BITS-1:0]   cpu_addr;
  logic [EW-1:0]           cpu_wdata;
  logic                    cpu_busy;
`ifdef PALETTE_READBACK_EN
  logic                    cpu_re;
  logic [EW-1:0]           cpu_rdata;
  logic                    cpu_rvalid;

  modport master (
    output pix_valid_in, pix_index, pix_blank, cpu_we, cpu_addr, cpu_wdata, cpu_re,
    input  pix_valid_out, r, g, b, cpu_busy, cpu_rdata, cpu_rvalid
  );
  modport slave (
    input  pix_valid_in, pix_index, pix_blank, cpu_we, cpu_addr, cpu_wdata, cpu_re,
    output pix_valid_out, r, g, b, cpu_busy, cpu_rdata, cpu_rvalid
  );
`else
  modport master (
    output pix_valid_in, pix_index, pix_blank, cpu_we, cpu_addr, cpu_wdata,
    input  pix_valid_out, r, g, b, cpu_busy
  );
  modport slave (
    input  pix_valid_in, pix_index, pix_blank, cpu_we, cpu_addr, cpu_wdata,
    output pix_valid_out, r, g, b, cpu_busy
  );
`endif
endinterface

// File: rtl/palette_lut.sv
// Palette RAM lookup: 2-stage pixel pipeline with blanking, CPU writes, grayscale init fill.
// Optional CPU readback port when PALETTE_READBACK_EN is defined.

// One colour channel of the output stage: holds when stage 1 is empty.
module palette_lut_chan #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_vld,
  input  logic         i_blank,
  input  logic [W-1:0] i_ent,
  output logic [W-1:0] o_ch
);
  logic [W-1:0] r_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ch <= '0;
    else if (i_vld) r_ch <= i_blank ? '0 : i_ent;
  end

  assign o_ch = r_ch;
endmodule

module palette_lut #(
  parameter int CHANNEL_BITS = 3,
  parameter int INDEX_BITS   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  palette_lut_if.slave  bus
);
  localparam int EW    = 3*CHANNEL_BITS;
  localparam int DEPTH = 1 << INDEX_BITS;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  logic [0:0]                        r_state;
  logic [INDEX_BITS-1:0]             r_cnt;
  logic [EW-1:0]                     r_mem [DEPTH];
  logic [EW-1:0]                     r_rd_data;
  logic [2:1]                        r_vld_pipe;
  logic                              r_s1_blank;

  logic                              w_run;
  logic                              w_cpu_re;
  logic                              w_mem_we;
  logic [INDEX_BITS-1:0]             w_wr_addr;
  logic [INDEX_BITS-1:0]             w_rd_addr;
  logic [EW-1:0]                     w_wr_data;
  logic [CHANNEL_BITS-1:0]           w_gray;
  logic [2:0][CHANNEL_BITS-1:0]      w_ent;
  logic [2:0][CHANNEL_BITS-1:0]      w_rgb;

  assign w_run = (r_state == S_RUN);

`ifdef PALETTE_READBACK_EN
  logic r_rvalid;

  assign w_cpu_re       = w_run & bus.cpu_re;
  assign bus.cpu_rdata  = r_rd_data;
  assign bus.cpu_rvalid = r_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rvalid <= 1'b0;
    else        r_rvalid <= w_cpu_re;
  end
`else
  assign w_cpu_re = 1'b0;
`endif

  // Gray level is the top CHANNEL_BITS of the index, zero-padded if the index is narrower.
  generate
    if (CHANNEL_BITS <= INDEX_BITS) begin : g_gray_msb
      assign w_gray = r_cnt[INDEX_BITS-1 -: CHANNEL_BITS];
    end else begin : g_gray_pad
      assign w_gray = {r_cnt, {(CHANNEL_BITS-INDEX_BITS){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else if (!w_run) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_IDX) r_state <= S_RUN;
    end
  end

  // Init sequencer owns the write port until RUN; CPU writes in INIT are dropped.
  assign w_mem_we  = w_run ? bus.cpu_we    : 1'b1;
  assign w_wr_addr = w_run ? bus.cpu_addr  : r_cnt;
  assign w_wr_data = w_run ? bus.cpu_wdata : {w_gray, w_gray, w_gray};
  assign w_rd_addr = w_cpu_re ? bus.cpu_addr : bus.pix_index;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wr_addr] <= w_wr_data;
  end

  // Read and write share the edge, so a same-address read returns the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_vld_pipe <= '0;
      r_s1_blank <= 1'b0;
    end else begin
      r_rd_data     <= r_mem[w_rd_addr];
      r_vld_pipe[1] <= w_run & bus.pix_valid_in & ~w_cpu_re;
      r_vld_pipe[2] <= r_vld_pipe[1];
      r_s1_blank    <= bus.pix_blank;
    end
  end

  assign w_ent = r_rd_data;

  generate
    for (genvar l = 0; l < 3; l++) begin : g_ch
      palette_lut_chan #(.W(CHANNEL_BITS)) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (r_vld_pipe[1]),
        .i_blank (r_s1_blank),
        .i_ent   (w_ent[l]),
        .o_ch    (w_rgb[l])
      );
    end
  endgenerate

  assign bus.r             = w_rgb[2];
  assign bus.g             = w_rgb[1];
  assign bus.b             = w_rgb[0];
  assign bus.pix_valid_out = r_vld_pipe[2];
  assign bus.cpu_busy      = ~w_run;
endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut: reference palette model, pixel/readback expectation queues.
// Readback checks are compiled in when PALETTE_READBACK_EN is defined.
module tb_palette_lut;
  localparam int CB    = 3;
  localparam int IB    = 8;
  localparam int EW    = 3*CB;
  localparam int DEPTH = 1 << IB;

  typedef struct {
    int            due;
    logic          vld;
    logic [EW-1:0] rgb;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  palette_lut_if #(.CHANNEL_BITS(CB), .INDEX_BITS(IB)) bus ();

  palette_lut #(.CHANNEL_BITS(CB), .INDEX_BITS(IB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t          pq[$];
  exp_t          rq[$];
  exp_t          m_e;
  logic [EW-1:0] model [DEPTH];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, since_rst = 0;
  int n_drop = 0, exp_drop = 0;
  int busy_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] gray(input int n);
    logic [CB-1:0] c;
    c = CB'((n >> (IB-CB)) & ((1 << CB) - 1));
    return {c, c, c};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (!rst_n) since_rst <= 0;
    else        since_rst <= since_rst + 1;
  end

  // Compare DUT outputs against whatever is due this cycle.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (pq.size() > 0 && pq[0].due == cyc) begin
        m_e = pq.pop_front();
        if (m_e.vld) begin
          chk("pix_vld", bus.pix_valid_out, 1);
          chk("pix_rgb", {bus.r, bus.g, bus.b}, m_e.rgb);
        end else begin
          chk("drop_vld", bus.pix_valid_out, 0);
          if (!bus.pix_valid_out) n_drop++;
        end
      end else if (bus.pix_valid_out) begin
        chk("unexp_vld", bus.pix_valid_out, 0);
      end
`ifdef PALETTE_READBACK_EN
      if (rq.size() > 0 && rq[0].due == cyc) begin
        m_e = rq.pop_front();
        chk("rb_vld", bus.cpu_rvalid, 1);
        chk("rb_data", bus.cpu_rdata, m_e.rgb);
      end else if (bus.cpu_rvalid) begin
        chk("rb_unexp", bus.cpu_rvalid, 0);
      end
`endif
    end
  end

  task automatic set_idle();
    bus.pix_valid_in = 1'b0;
    bus.pix_index    = '0;
    bus.pix_blank    = 1'b0;
    bus.cpu_we       = 1'b0;
    bus.cpu_addr     = '0;
    bus.cpu_wdata    = '0;
`ifdef PALETTE_READBACK_EN
    bus.cpu_re       = 1'b0;
`endif
  endtask

  // One cycle of stimulus; expectations follow read-before-write on the model.
  task automatic drive(input logic v, input int idx, input logic bl,
                       input logic we = 1'b0, input int ad = 0, input int wd = 0,
                       input logic re = 1'b0);
    exp_t e;
    logic run;
    @(negedge clk);
    run = (since_rst >= DEPTH);
    bus.pix_valid_in = v;
    bus.pix_index    = IB'(idx);
    bus.pix_blank    = bl;
    bus.cpu_we       = we;
    bus.cpu_addr     = IB'(ad);
    bus.cpu_wdata    = EW'(wd);
`ifdef PALETTE_READBACK_EN
    bus.cpu_re       = re;
`endif
    if (run) begin
      if (v) begin
        e.due = cyc + 2;
        e.vld = !re;
        e.rgb = bl ? '0 : model[idx & (DEPTH-1)];
        if (re) exp_drop++;
        pq.push_back(e);
      end
      if (re) begin
        e.due = cyc + 1;
        e.vld = 1'b1;
        e.rgb = model[ad & (DEPTH-1)];
        rq.push_back(e);
      end
      if (we) model[ad & (DEPTH-1)] = EW'(wd);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    pq.delete();
    rq.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = gray(i);
    #1;
    chk("rst_vld", bus.pix_valid_out, 0);
    chk("rst_rgb", {bus.r, bus.g, bus.b}, 0);
    chk("rst_busy", bus.cpu_busy, 1);
`ifdef PALETTE_READBACK_EN
    chk("rst_rvalid", bus.cpu_rvalid, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle();
    do_reset();

    // Partial INIT with discarded pixels, then reset at cycle 100.
    for (int i = 1; i < 100; i++) drive(1'b1, i, 1'b0, i == 50, 'h10, 'h1FF);
    chk("init_vld", bus.pix_valid_out, 0);
    chk("init_busy", bus.cpu_busy, 1);
    do_reset();

    // Full INIT: measure busy length, dropped write at 50, ignored readback at 60.
    busy_cnt = bus.cpu_busy ? 1 : 0;
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, $urandom_range(0, DEPTH-1), 1'b0, busy_cnt == 50, 'h10, 'h1FF,
            busy_cnt == 60);
      if (!bus.cpu_busy) break;
      busy_cnt++;
    end
    chk("init_len", busy_cnt, DEPTH);

    drive(1'b1, 'hFF, 1'b0);
    drive(1'b1, 'h20, 1'b0);
    drive(1'b1, 'h10, 1'b0);
    drive(1'b1, 'hFF, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 1'b0);

    drive(1'b0, 0, 1'b0, 1'b1, 'h05, 'h1C0);
    drive(1'b1, 'h05, 1'b0);
    drive(1'b1, 'h05, 1'b0, 1'b1, 'h05, 'h038);
    drive(1'b1, 'h05, 1'b0);
    drive(1'b1, 'hFF, 1'b1);
    drive(1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom_range(0, 511));

`ifdef PALETTE_READBACK_EN
    drive(1'b0, 0, 1'b0, 1'b1, 'h33, 'h155);
    drive(1'b1, 'h40, 1'b0, 1'b0, 'h33, 0, 1'b1);
    drive(1'b1, 'h33, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1, 'h33, 'h0AA, 1'b1);
    drive(1'b1, 'h33, 1'b0, 1'b0, 'h34, 0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0, 'h33, 0, 1'b1);
`endif
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0);

    // Mid-frame reset: pipeline clears and the CPU-written entry reverts to gray.
    drive(1'b1, 'h05, 1'b0);
    drive(1'b1, 'hFF, 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 0, 1'b0);
    drive(1'b1, 'h05, 1'b0);
    drive(1'b1, 'h33, 1'b0);
    drive(1'b1, 'hE0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0);

    chk("sb_empty", pq.size(), 0);
    chk("rb_empty", rq.size(), 0);
    chk("drop_cnt", n_drop, exp_drop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
